// File: rtl/i2c_pkg.sv
// ---------------------------------------------------------------------------
// i2c_pkg
// Shared declarations for the oversampled I2C target:
//   - i2c_state_e      : target FSM state encoding
//   - I2C_READ/WRITE   : meaning of the R/W bit in the address byte
//   - I2C_DEFAULT_ADDR : default 7-bit target address (0x5A write / 0x5B read)
//   - shift_bit()      : serial shift helper honouring the wire bit order
//   - wire_bit()       : bit of a byte that goes on the wire next
// ---------------------------------------------------------------------------
package i2c_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_ADDR_ACK,
      ST_RX,
      ST_RX_ACK,
      ST_TX,
      ST_TX_ACK,
      ST_IGNORE
   } i2c_state_e;

   localparam logic       I2C_READ         = 1'b1;
   localparam logic       I2C_WRITE        = 1'b0;
   localparam logic [6:0] I2C_DEFAULT_ADDR = 7'h2D;

   // Shift one wire bit into a byte. With LSB-first order the first wire
   // bit ends up in bit 0 after eight shifts.
   function automatic logic [7:0] shift_bit(input logic [7:0] cur,
                                            input logic       b,
                                            input logic       lsb_first);
      return lsb_first ? {b, cur[7:1]} : {cur[6:0], b};
   endfunction

   // The bit of the shifter that is currently presented on the wire.
   function automatic logic wire_bit(input logic [7:0] cur,
                                     input logic       lsb_first);
      return lsb_first ? cur[0] : cur[7];
   endfunction

endpackage

// File: rtl/i2c_in_sync.sv
// ---------------------------------------------------------------------------
// i2c_in_sync
// Conditions one asynchronous bus line: 2-FF synchronizer (preset to the
// idle-high bus level), optional glitch filter, then an edge register.
// level/rise/fall are all aligned: on the cycle rise or fall pulses, level
// already shows the new value. Pin-to-edge latency is 3 clk, plus
// FILTER_LEN when the filter is compiled in.
//
// Optional feature macro: I2C_TARGET_FILTER_EN
//   defined   -> the synchronized value must be seen FILTER_LEN consecutive
//                cycles before it is accepted; shorter pulses vanish.
//   undefined -> synchronizer output feeds the edge register directly.
//
// Ports:
//   clk   in   system clock
//   rst   in   asynchronous active-low reset
//   pin   in   raw bus line
//   level out  conditioned line level
//   rise  out  one-cycle pulse on a conditioned rising edge
//   fall  out  one-cycle pulse on a conditioned falling edge
// ---------------------------------------------------------------------------
module i2c_in_sync
   import i2c_pkg::*;
#(
   parameter int FILTER_LEN = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic pin,
   output logic level,
   output logic rise,
   output logic fall
);

   logic meta_reg;
   logic sync_reg;
   logic clean;
   logic prev_reg;
   logic rise_reg;
   logic fall_reg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         meta_reg <= 1'b1;
         sync_reg <= 1'b1;
      end else begin
         meta_reg <= pin;
         sync_reg <= meta_reg;
      end
   end

`ifdef I2C_TARGET_FILTER_EN
   localparam int CNT_W = $clog2(FILTER_LEN + 1);

   logic             filt_reg;
   logic [CNT_W-1:0] cnt_reg;

   // cnt_reg counts consecutive samples that disagree with the accepted
   // level; any agreeing sample restarts the count.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         filt_reg <= 1'b1;
         cnt_reg  <= '0;
      end else if (sync_reg == filt_reg) begin
         cnt_reg  <= '0;
      end else if (cnt_reg == CNT_W'(FILTER_LEN - 1)) begin
         filt_reg <= sync_reg;
         cnt_reg  <= '0;
      end else begin
         cnt_reg  <= cnt_reg + CNT_W'(1);
      end
   end

   assign clean = filt_reg;
`else
   logic unused_filter_len;
   assign unused_filter_len = (FILTER_LEN > 0);
   assign clean = sync_reg;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         prev_reg <= 1'b1;
         rise_reg <= 1'b0;
         fall_reg <= 1'b0;
      end else begin
         prev_reg <= clean;
         rise_reg <= clean & ~prev_reg;
         fall_reg <= ~clean & prev_reg;
      end
   end

   assign level = prev_reg;
   assign rise  = rise_reg;
   assign fall  = fall_reg;

endmodule

// File: rtl/i2c_target.sv
// ---------------------------------------------------------------------------
// i2c_target
// Oversampled I2C target. SCL and SDA are sampled by clk (never used as a
// clock), START/STOP are detected, a 7-bit address is matched, and bytes
// are exchanged with a parallel byte interface.
//
// Optional feature macro: I2C_TARGET_FILTER_EN (input glitch filter of
// FILTER_LEN samples inside i2c_in_sync).
//
// Ports:
//   clk       in   system clock
//   rst       in   asynchronous active-low reset
//   scl       in   serial clock from the master
//   sda_in    in   serial data from the master
//   sda_out   out  serial data to the master (1 = released, 0 = pull low)
//   rx_data   out  [7:0] last byte written by the master
//   rx_valid  out  one-cycle pulse when rx_data updates
//   tx_data   in   [7:0] byte returned on a read, captured while tx_load=1
//   tx_load   out  one-cycle pulse; tx_data is captured at the end of it
//   busy      out  high from an address match until START or STOP
//   nack_seen out  one-cycle pulse when the master NACKs a read byte
// ---------------------------------------------------------------------------
module i2c_target
   import i2c_pkg::*;
#(
   parameter logic [6:0] ADDR       = I2C_DEFAULT_ADDR,
   parameter bit         LSB_FIRST  = 1'b1,
   parameter int         FILTER_LEN = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       scl,
   input  logic       sda_in,
   output logic       sda_out,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic [7:0] tx_data,
   output logic       tx_load,
   output logic       busy,
   output logic       nack_seen
);

   logic scl_lvl, scl_rise, scl_fall;
   logic sda_lvl, sda_rise, sda_fall;

   i2c_in_sync #(.FILTER_LEN(FILTER_LEN)) u_scl_sync (
      .clk   (clk),
      .rst   (rst),
      .pin   (scl),
      .level (scl_lvl),
      .rise  (scl_rise),
      .fall  (scl_fall)
   );

   i2c_in_sync #(.FILTER_LEN(FILTER_LEN)) u_sda_sync (
      .clk   (clk),
      .rst   (rst),
      .pin   (sda_in),
      .level (sda_lvl),
      .rise  (sda_rise),
      .fall  (sda_fall)
   );

   // Both lines share the same conditioning latency, so scl_lvl is the SCL
   // level at the moment the SDA edge happened.
   logic start_cond;
   logic stop_cond;
   assign start_cond = sda_fall & scl_lvl;
   assign stop_cond  = sda_rise & scl_lvl;

   i2c_state_e state_reg,     state_next;
   logic [2:0] bit_cnt_reg,   bit_cnt_next;
   logic [7:0] shift_reg,     shift_next;
   logic       rw_reg,        rw_next;
   logic       sda_out_reg,   sda_out_next;
   logic [7:0] rx_data_reg,   rx_data_next;
   logic       rx_valid_reg,  rx_valid_next;
   logic       busy_reg,      busy_next;
   logic       nack_reg,      nack_next;
   logic       load_now;
   logic [7:0] shifted;

   assign shifted = shift_bit(shift_reg, sda_lvl, LSB_FIRST);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg    <= ST_IDLE;
         bit_cnt_reg  <= 3'd0;
         shift_reg    <= 8'h00;
         rw_reg       <= I2C_WRITE;
         sda_out_reg  <= 1'b1;
         rx_data_reg  <= 8'h00;
         rx_valid_reg <= 1'b0;
         busy_reg     <= 1'b0;
         nack_reg     <= 1'b0;
      end else begin
         state_reg    <= state_next;
         bit_cnt_reg  <= bit_cnt_next;
         shift_reg    <= shift_next;
         rw_reg       <= rw_next;
         sda_out_reg  <= sda_out_next;
         rx_data_reg  <= rx_data_next;
         rx_valid_reg <= rx_valid_next;
         busy_reg     <= busy_next;
         nack_reg     <= nack_next;
      end
   end

   // sda_out_next is only changed on scl_fall (or by START/STOP/IGNORE,
   // which only ever release), so the line moves one clk after the fall.
   // In the ACK states sda_out_reg doubles as the "ACK already driven"
   // marker: the first fall pulls low, the second fall ends the ACK.
   always_comb begin
      state_next    = state_reg;
      bit_cnt_next  = bit_cnt_reg;
      shift_next    = shift_reg;
      rw_next       = rw_reg;
      sda_out_next  = sda_out_reg;
      rx_data_next  = rx_data_reg;
      rx_valid_next = 1'b0;
      busy_next     = busy_reg;
      nack_next     = 1'b0;
      load_now      = 1'b0;

      if (start_cond) begin
         state_next   = ST_ADDR;
         bit_cnt_next = 3'd0;
         sda_out_next = 1'b1;
         busy_next    = 1'b0;
      end else if (stop_cond) begin
         state_next   = ST_IDLE;
         bit_cnt_next = 3'd0;
         sda_out_next = 1'b1;
         busy_next    = 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               sda_out_next = 1'b1;
            end

            ST_ADDR: begin
               if (scl_rise) begin
                  shift_next   = shifted;
                  bit_cnt_next = bit_cnt_reg + 3'd1;
                  if (bit_cnt_reg == 3'd7) begin
                     if (shifted[7:1] == ADDR) begin
                        state_next = ST_ADDR_ACK;
                        rw_next    = shifted[0];
                        busy_next  = 1'b1;
                     end else begin
                        state_next = ST_IGNORE;
                     end
                  end
               end
            end

            ST_ADDR_ACK: begin
               if (scl_fall) begin
                  if (sda_out_reg) begin
                     sda_out_next = 1'b0;
                  end else if (rw_reg == I2C_WRITE) begin
                     sda_out_next = 1'b1;
                     state_next   = ST_RX;
                  end else begin
                     // The fall that ends the ACK is also the one that
                     // presents the first data bit, so load and drive now.
                     load_now     = 1'b1;
                     shift_next   = tx_data;
                     sda_out_next = wire_bit(tx_data, LSB_FIRST);
                     state_next   = ST_TX;
                  end
               end
            end

            ST_RX: begin
               if (scl_rise) begin
                  shift_next   = shifted;
                  bit_cnt_next = bit_cnt_reg + 3'd1;
                  if (bit_cnt_reg == 3'd7) begin
                     rx_data_next  = shifted;
                     rx_valid_next = 1'b1;
                     state_next    = ST_RX_ACK;
                  end
               end
            end

            ST_RX_ACK: begin
               if (scl_fall) begin
                  if (sda_out_reg) begin
                     sda_out_next = 1'b0;
                  end else begin
                     sda_out_next = 1'b1;
                     state_next   = ST_RX;
                  end
               end
            end

            ST_TX: begin
               // The shifter advances on each rise so the next fall always
               // presents wire_bit(shift_reg).
               if (scl_fall) begin
                  sda_out_next = wire_bit(shift_reg, LSB_FIRST);
               end else if (scl_rise) begin
                  shift_next   = shift_bit(shift_reg, 1'b0, LSB_FIRST);
                  bit_cnt_next = bit_cnt_reg + 3'd1;
                  if (bit_cnt_reg == 3'd7) begin
                     state_next = ST_TX_ACK;
                  end
               end
            end

            ST_TX_ACK: begin
               if (scl_fall) begin
                  sda_out_next = 1'b1;
               end else if (scl_rise) begin
                  if (!sda_lvl) begin
                     load_now   = 1'b1;
                     shift_next = tx_data;
                     state_next = ST_TX;
                  end else begin
                     nack_next  = 1'b1;
                     state_next = ST_IGNORE;
                  end
               end
            end

            ST_IGNORE: begin
               sda_out_next = 1'b1;
            end

            default: begin
               state_next   = ST_IDLE;
               sda_out_next = 1'b1;
            end
         endcase
      end
   end

   assign sda_out   = sda_out_reg;
   assign rx_data   = rx_data_reg;
   assign rx_valid  = rx_valid_reg;
   assign tx_load   = load_now;
   assign busy      = busy_reg;
   assign nack_seen = nack_reg;

endmodule

// File: tb/tb_i2c_target.sv
// ---------------------------------------------------------------------------
// tb_i2c_target
// Self-checking bench for i2c_target. A behavioural bus master drives
// scl/sda_in with 10-clk phases; expectations come from the protocol rules
// (address match, ACK per byte, LSB-first wire order, read NACK ends the
// read). Monitors count output pulses and log captured bytes.
// ---------------------------------------------------------------------------
module tb_i2c_target;

   localparam int PH = 10;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       scl = 1'b1;
   logic       sda_in = 1'b1;
   logic       sda_out;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic [7:0] tx_data = 8'h00;
   logic       tx_load;
   logic       busy;
   logic       nack_seen;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   i2c_target dut (
      .clk       (clk),
      .rst       (rst),
      .scl       (scl),
      .sda_in    (sda_in),
      .sda_out   (sda_out),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .tx_data   (tx_data),
      .tx_load   (tx_load),
      .busy      (busy),
      .nack_seen (nack_seen)
   );

   // ---------------- monitors ----------------
   int         rxv_cnt  = 0;
   int         txl_cnt  = 0;
   int         nack_cnt = 0;
   int         low_cnt  = 0;
   logic [7:0] rx_log [0:255];
   logic [7:0] tx_log [0:255];

   always @(posedge clk) begin
      if (rx_valid) begin
         rx_log[rxv_cnt[7:0]] <= rx_data;
         rxv_cnt <= rxv_cnt + 1;
      end
      if (tx_load) begin
         tx_log[txl_cnt[7:0]] <= tx_data;
         txl_cnt <= txl_cnt + 1;
      end
      if (nack_seen) nack_cnt <= nack_cnt + 1;
      if (sda_out === 1'b0) low_cnt <= low_cnt + 1;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: time limit reached, got no finish, expected finish");
      $fatal(1);
   end

   // ---------------- bus master ----------------
   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bus_start();
      if (scl == 1'b0) begin
         wait_clk(2);
         sda_in = 1'b1;
         wait_clk(PH);
         scl = 1'b1;
         wait_clk(PH);
      end
      sda_in = 1'b0;
      wait_clk(PH);
      scl = 1'b0;
   endtask

   task automatic bus_stop();
      wait_clk(2);
      sda_in = 1'b0;
      wait_clk(PH);
      scl = 1'b1;
      wait_clk(PH);
      sda_in = 1'b1;
      wait_clk(PH);
   endtask

   // One SCL period; returns the target's line sampled mid-high.
   task automatic bus_bit(input logic b, output logic seen);
      wait_clk(2);
      sda_in = b;
      wait_clk(PH - 2);
      scl = 1'b1;
      wait_clk(PH / 2);
      seen = sda_out;
      wait_clk(PH - PH / 2);
      scl = 1'b0;
   endtask

   // Master writes a byte LSB first, then releases for the ACK slot.
   task automatic bus_byte(input logic [7:0] b, output logic ack);
      logic s;
      for (int i = 0; i < 8; i++) bus_bit(b[i], s);
      bus_bit(1'b1, ack);
   endtask

   // Master reads a byte; next_tx is presented after the first bit.
   task automatic read_byte(input logic nack, input logic [7:0] next_tx,
                            output logic [7:0] got);
      logic s;
      for (int i = 0; i < 8; i++) begin
         bus_bit(1'b1, s);
         got[i] = s;
         if (i == 0) tx_data = next_tx;
      end
      bus_bit(nack, s);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b0;
      wait_clk(3);
      n_vec++; if (sda_out !== 1'b1) begin n_err++; $display("FAIL rst_sda_out: got %b expected 1", sda_out); end
      n_vec++; if (rx_data !== 8'h00) begin n_err++; $display("FAIL rst_rx_data: got %h expected 00", rx_data); end
      n_vec++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL rst_rx_valid: got %b expected 0", rx_valid); end
      n_vec++; if (tx_load !== 1'b0) begin n_err++; $display("FAIL rst_tx_load: got %b expected 0", tx_load); end
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b expected 0", busy); end
      n_vec++; if (nack_seen !== 1'b0) begin n_err++; $display("FAIL rst_nack_seen: got %b expected 0", nack_seen); end
      rst = 1'b1;
      wait_clk(5);
      $display("reset: outputs checked");
   endtask

   task automatic test_write();
      for (int t = 0; t < 5; t++) begin
         int         nb;
         int         rx0;
         logic       ack;
         logic [7:0] d [4];
         nb  = (t == 0) ? 1 : int'($urandom_range(1, 4));
         rx0 = rxv_cnt;
         bus_start();
         bus_byte(8'h5A, ack);
         n_vec++; if (ack !== 1'b0) begin n_err++; $display("FAIL wr_addr_ack: got %b expected 0", ack); end
         for (int b = 0; b < nb; b++) begin
            d[b] = (t == 0) ? 8'hC3 : 8'($urandom);
            bus_byte(d[b], ack);
            n_vec++; if (ack !== 1'b0) begin n_err++; $display("FAIL wr_data_ack: byte %0d got %b expected 0", b, ack); end
         end
         n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL wr_busy: got %b expected 1", busy); end
         n_vec++; if (rxv_cnt - rx0 !== nb) begin n_err++; $display("FAIL wr_rx_valid_count: got %0d expected %0d", rxv_cnt - rx0, nb); end
         for (int b = 0; b < nb; b++) begin
            n_vec++; if (rx_log[(rx0 + b) % 256] !== d[b]) begin n_err++; $display("FAIL wr_rx_data: byte %0d got %h expected %h", b, rx_log[(rx0 + b) % 256], d[b]); end
         end
         n_vec++; if (rx_data !== d[nb-1]) begin n_err++; $display("FAIL wr_rx_data_port: got %h expected %h", rx_data, d[nb-1]); end
         bus_stop();
         n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL wr_busy_stop: got %b expected 0", busy); end
         $display("write txn %0d: %0d bytes, last %h", t, nb, d[nb-1]);
      end
   endtask

   task automatic test_mismatch();
      for (int t = 0; t < 4; t++) begin
         logic [7:0] a;
         logic [7:0] d;
         logic       ack;
         int         low0;
         int         rx0;
         a = 8'h5C;
         if (t != 0) begin
            a = 8'($urandom);
            while (a[7:1] == 7'h2D) a = 8'($urandom);
         end
         d    = (t == 0) ? 8'hC3 : 8'($urandom);
         low0 = low_cnt;
         rx0  = rxv_cnt;
         bus_start();
         bus_byte(a, ack);
         n_vec++; if (ack !== 1'b1) begin n_err++; $display("FAIL mm_addr_ack: addr %h got %b expected 1", a, ack); end
         bus_byte(d, ack);
         n_vec++; if (ack !== 1'b1) begin n_err++; $display("FAIL mm_data_ack: got %b expected 1", ack); end
         n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL mm_busy: got %b expected 0", busy); end
         bus_stop();
         n_vec++; if (low_cnt !== low0) begin n_err++; $display("FAIL mm_sda_low: got %0d low cycles expected 0", low_cnt - low0); end
         n_vec++; if (rxv_cnt !== rx0) begin n_err++; $display("FAIL mm_rx_valid: got %0d pulses expected 0", rxv_cnt - rx0); end
         $display("mismatch txn %0d: addr byte %h", t, a);
      end
   endtask

   task automatic test_read();
      for (int t = 0; t < 4; t++) begin
         int         nb;
         int         tl0;
         int         nk0;
         logic       ack;
         logic [7:0] got;
         logic [7:0] v [5];
         nb = (t == 0) ? 1 : int'($urandom_range(1, 3));
         for (int i = 0; i < 5; i++) v[i] = 8'($urandom);
         if (t == 0) v[0] = 8'hA5;
         tx_data = v[0];
         tl0 = txl_cnt;
         nk0 = nack_cnt;
         bus_start();
         bus_byte(8'h5B, ack);
         n_vec++; if (ack !== 1'b0) begin n_err++; $display("FAIL rd_addr_ack: got %b expected 0", ack); end
         for (int b = 0; b < nb; b++) begin
            read_byte(b == nb - 1, v[b+1], got);
            n_vec++; if (got !== v[b]) begin n_err++; $display("FAIL rd_wire_bits: byte %0d got %h expected %h", b, got, v[b]); end
         end
         wait_clk(6);
         n_vec++; if (sda_out !== 1'b1) begin n_err++; $display("FAIL rd_release: got %b expected 1", sda_out); end
         n_vec++; if (txl_cnt - tl0 !== nb) begin n_err++; $display("FAIL rd_tx_load_count: got %0d expected %0d", txl_cnt - tl0, nb); end
         n_vec++; if (tx_log[tl0 % 256] !== v[0]) begin n_err++; $display("FAIL rd_tx_capture: got %h expected %h", tx_log[tl0 % 256], v[0]); end
         n_vec++; if (nack_cnt - nk0 !== 1) begin n_err++; $display("FAIL rd_nack_count: got %0d expected 1", nack_cnt - nk0); end
         bus_stop();
         $display("read txn %0d: %0d bytes, first %h", t, nb, v[0]);
      end
   endtask

   task automatic test_restart();
      int         rx0;
      logic       ack;
      logic       s;
      logic [7:0] d;
      rx0 = rxv_cnt;
      bus_start();
      bus_byte(8'h5A, ack);
      for (int i = 0; i < 4; i++) bus_bit(1'($urandom), s);
      bus_start();
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rs_busy: got %b expected 0", busy); end
      bus_byte(8'h5A, ack);
      n_vec++; if (ack !== 1'b0) begin n_err++; $display("FAIL rs_addr_ack: got %b expected 0", ack); end
      n_vec++; if (rxv_cnt !== rx0) begin n_err++; $display("FAIL rs_partial_rx_valid: got %0d pulses expected 0", rxv_cnt - rx0); end
      d = 8'($urandom);
      bus_byte(d, ack);
      n_vec++; if (rx_log[rx0 % 256] !== d || rxv_cnt - rx0 !== 1) begin n_err++; $display("FAIL rs_rx_data: got %h x%0d expected %h x1", rx_log[rx0 % 256], rxv_cnt - rx0, d); end
      bus_stop();
      $display("restart txn: byte %h", d);
   endtask

   task automatic test_reset_mid();
      logic       ack;
      logic       s;
      logic [7:0] d;
      int         rx0;
      tx_data = 8'hA5;
      bus_start();
      bus_byte(8'h5B, ack);
      for (int i = 0; i < 3; i++) bus_bit(1'b1, s);
      wait_clk(8);
      n_vec++; if (sda_out !== 1'b0) begin n_err++; $display("FAIL rm_bit3_driven: got %b expected 0", sda_out); end
      rst = 1'b0;
      #1;
      n_vec++; if (sda_out !== 1'b1) begin n_err++; $display("FAIL rm_async_release: got %b expected 1", sda_out); end
      n_vec++; if (busy !== 1'b0 || rx_valid !== 1'b0 || tx_load !== 1'b0 || nack_seen !== 1'b0 || rx_data !== 8'h00)
         begin n_err++; $display("FAIL rm_outputs: got busy %b rv %b tl %b nk %b rx %h expected 0 0 0 0 00", busy, rx_valid, tx_load, nack_seen, rx_data); end
      wait_clk(2);
      scl = 1'b1;
      sda_in = 1'b1;
      wait_clk(3);
      rst = 1'b1;
      wait_clk(5);
      rx0 = rxv_cnt;
      d = 8'($urandom);
      bus_start();
      bus_byte(8'h5A, ack);
      n_vec++; if (ack !== 1'b0) begin n_err++; $display("FAIL rm_new_addr_ack: got %b expected 0", ack); end
      bus_byte(d, ack);
      n_vec++; if (rx_log[rx0 % 256] !== d || rxv_cnt - rx0 !== 1) begin n_err++; $display("FAIL rm_new_rx: got %h x%0d expected %h x1", rx_log[rx0 % 256], rxv_cnt - rx0, d); end
      bus_stop();
      $display("reset mid-read, then write %h", d);
   endtask

   task automatic test_glitch();
      logic ack;
      logic exp_ack;
`ifdef I2C_TARGET_FILTER_EN
      exp_ack = 1'b1;
`else
      exp_ack = 1'b0;
`endif
      wait_clk(PH);
      sda_in = 1'b0;
      wait_clk(2);
      sda_in = 1'b1;
      scl = 1'b0;
      bus_byte(8'h5A, ack);
      n_vec++; if (ack !== exp_ack) begin n_err++; $display("FAIL glitch_start: got ack %b expected %b", ack, exp_ack); end
      bus_stop();
      $display("glitch txn: ack slot %b", ack);
   endtask

   initial begin
      test_reset();
      test_write();
      test_mismatch();
      test_read();
      test_restart();
      test_reset_mid();
      test_glitch();
      wait_clk(5);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/i2c_target.md
# i2c_target

Oversampled I2C target (slave) that sits directly downstream of the bus `master`. It consumes the master's `sclk`/`sda_out` and returns `sda_in`. The block detects START and STOP, matches a 7-bit address, ACKs, and moves bytes between the bus and a simple parallel byte interface. The system clock samples the bus; nothing is clocked by SCL.

## Interface
Parameters:
- `ADDR`, 7'h2D: own 7-bit address. The address byte 0x5A selects a write and 0x5B selects a read.
- `LSB_FIRST`, 1: serial bit order. 1 means bit 0 is first on the wire, matching the bus master; 0 means MSB first.
- `FILTER_LEN`, 3: stable-sample count for the input glitch filter. Used only when the filter is compiled in.

Ports:
- `clk`  in  1  system clock. Every register is clocked on its rising edge.
- `rst`  in  1  reset. Asynchronous and active-low.
- `scl`  in  1  serial clock from the master.
- `sda_in`  in  1  serial data from the master.
- `sda_out`  out  1  serial data to the master. 1 releases the line; 0 pulls it low.
- `rx_data`  out  8  last byte written by the master.
- `rx_valid`  out  1  one-cycle pulse when `rx_data` updates.
- `tx_data`  in  8  byte to return on a read. Sampled on the `tx_load` cycle.
- `tx_load`  out  1  one-cycle pulse at which `tx_data` is captured.
- `busy`  out  1  high from an address match until STOP or START.
- `nack_seen`  out  1  one-cycle pulse when the master NACKs a read byte.

## Operation
- **Input conditioning.** `scl` and `sda_in` each pass through a 2-FF synchronizer and then one edge register. This yields `scl_rise`, `scl_fall`, `sda_rise` and `sda_fall`.
- **Bus conditions.**
  - START is `sda_fall` while `scl` is high.
  - STOP is `sda_rise` while `scl` is high.
  - Both are evaluated in every state and take priority over all other transitions.
- **Data sampling.** Bits are sampled on `scl_rise`. `sda_out` changes only on the cycle after `scl_fall`.
- **States:** IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK, IGNORE.
  - IDLE: on START, go to ADDR.
  - ADDR: shift in 8 bits. Bits [7:1] are the address and bit 0 is R/W.
    - On a match, go to ADDR_ACK and set `busy`.
    - On a mismatch, go to IGNORE.
  - ADDR_ACK: drive 0 for one SCL period, from the first `scl_fall` to the next `scl_fall`, then release.
    - If R/W=0, go to RX.
    - If R/W=1, pulse `tx_load` on that same `scl_fall`, load the shifter, and go to TX.
  - RX: after 8 bits, update `rx_data`, pulse `rx_valid`, then go to RX_ACK. Every byte is ACKed; there is no backpressure.
  - RX_ACK: drive 0 for one SCL period, then go to RX.
  - TX: drive the shifter bit after each `scl_fall`. After 8 bits, release and go to TX_ACK.
  - TX_ACK: sample `sda_in` on `scl_rise`.
    - If 0 (ACK), pulse `tx_load`, reload, and go to TX.
    - If 1 (NACK), pulse `nack_seen` and go to IGNORE.
  - IGNORE: hold `sda_out`=1 until START or STOP.
- **Bit counter.** 3 bits, wraps 7 to 0. A byte is complete when the counter wraps on `scl_rise`.
- **START or STOP mid-byte.** Abort the transfer: counter to 0, `sda_out`=1, `busy`=0. No `rx_valid` for the partial byte. A repeated START re-enters ADDR.
- **Reset.** Asserting `rst` mid-transfer forces IDLE immediately and releases the line.

## Timing
- Reset values:
  - `sda_out`=1
  - `rx_data`=8'h00
  - `rx_valid`=0
  - `tx_load`=0
  - `busy`=0
  - `nack_seen`=0
  - synchronizers preset to 1 (bus idle)
- Latency from pin to detected edge: 3 `clk`. With the filter compiled in: 3+`FILTER_LEN`.
- `sda_out` update: 1 `clk` after `scl_fall` detect, giving 4 `clk` from the SCL pin.
- `rx_valid`: asserts 1 `clk` after the 8th `scl_rise` detect.
- Minimum SCL high or low phase for correct operation: 6 `clk`, or 6+`FILTER_LEN` with the filter. The bus master's /8-per-phase prescale meets this.
- Simultaneous events: if START/STOP and a data edge land on the same cycle, START/STOP wins.

## Configuration
- `I2C_TARGET_FILTER_EN` defined:
  - Each synchronized input updates only after `FILTER_LEN` consecutive equal samples.
  - Shorter pulses are discarded.
- Undefined: the synchronizer outputs are used directly and `FILTER_LEN` is ignored.

## Structure
- Shared package `i2c_pkg` holds:
  - the state enum
  - `I2C_READ`=1 and `I2C_WRITE`=0
  - the default address constant
- One sub-module, `i2c_in_sync`, implements the synchronizer, optional filter and edge detector. It is instantiated twice, once for `scl` and once for `sda_in`.
- The FSM and shifter live in `i2c_target`.

## Test plan
- Write: START, 0x5A, 0xC3, STOP → ACK on both bytes; `rx_data`=8'hC3 with one `rx_valid` pulse; `busy` falls at STOP.
- Mismatch: START, 0x5C, 0xC3 → `sda_out` stays 1 throughout; no `rx_valid`; `busy`=0.
- Read with `tx_data`=8'hA5 and `LSB_FIRST`=1: START, 0x5B, then master NACK → wire bits 1,0,1,0,0,1,0,1; one `tx_load`; one `nack_seen`; `sda_out`=1 after the NACK.
- Repeated START after 4 bits of an RX byte, then 0x5A → no `rx_valid` for the partial byte; ADDR_ACK follows.
- `rst` low during TX bit 3 → `sda_out`=1 in the same cycle; all outputs at reset values; a new START works.
- With `I2C_TARGET_FILTER_EN`: a 2-`clk` low glitch on `sda_in` while `scl` is high → no START detected. Without the macro → START detected.
